// File: rtl/code_counter_pkg.sv
// code_counter_pkg: shared width, code type, default parameters and clamp helper
package code_counter_pkg;
  localparam int CODE_W = 5;
  typedef logic [CODE_W-1:0] code_t;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int MAX_CODE_DEF = 31;
  function automatic code_t clamp_code(input code_t v, input code_t mx);
    return v > mx ? mx : v;
  endfunction
endpackage

// File: rtl/code_counter_if.sv
// code_counter_if: button/switch inputs and 7-segment code outputs of code_counter
interface code_counter_if;
  import code_counter_pkg::*;
  logic btn_up;
  logic btn_down;
  logic btn_load;
  code_t load_val;
  logic hold;
  logic c1;
  logic c2;
  logic c3;
  logic c4;
  logic c5;
  logic wrap;
  modport master (output btn_up, btn_down, btn_load, load_val, hold, input c1, c2, c3, c4, c5, wrap);
  modport slave (input btn_up, btn_down, btn_load, load_val, hold, output c1, c2, c3, c4, c5, wrap);
endinterface

// File: rtl/code_counter_button_debounce.sv
// button_debounce: synchroniser, optional filter (CODE_COUNTER_DEBOUNCE_EN) and rising-edge step pulse
module button_debounce
  import code_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic step_o
);
  logic [1:0] sync_q;
  logic filt, prev_q, step_q;
`ifdef CODE_COUNTER_DEBOUNCE_EN
  logic [7:0] cnt_q, cnt_d;
  logic filt_q, filt_d, flip;
  always_comb begin
    flip = sync_q[1] != filt_q && cnt_q == 8'(DEB_CYCLES - 1);
    cnt_d = (sync_q[1] == filt_q || flip) ? '0 : cnt_q + 8'd1;
    filt_d = flip ? sync_q[1] : filt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      filt_q <= filt_d;
    end
  end
  assign filt = filt_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign filt = sync_q[1];
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      prev_q <= filt;
      step_q <= filt & ~prev_q;
    end
  end
  assign step_o = step_q;
endmodule

// File: rtl/code_counter.sv
// code_counter: button-driven wrapping 5-bit code source for the 7-segment decoder (CODE_COUNTER_DEBOUNCE_EN enables filtering)
module code_counter
  import code_counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MAX_CODE = MAX_CODE_DEF
) (
  input logic clk,
  input logic rst_n,
  code_counter_if.slave bus
);
  localparam code_t MAX = code_t'(MAX_CODE);
  logic up, dn, ld;
  code_t count_q, count_d;
  logic wrap_q, wrap_d;
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (.clk(clk), .rst_n(rst_n), .raw_i(bus.btn_up), .step_o(up));
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (.clk(clk), .rst_n(rst_n), .raw_i(bus.btn_down), .step_o(dn));
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ld (.clk(clk), .rst_n(rst_n), .raw_i(bus.btn_load), .step_o(ld));
  always_comb begin
    count_d = ld ? clamp_code(bus.load_val, MAX)
            : ((up && dn) || bus.hold) ? count_q
            : up ? (count_q == MAX ? '0 : count_q + 5'd1)
            : dn ? (count_q == '0 ? MAX : count_q - 5'd1)
            : count_q;
    wrap_d = !ld && !(up && dn) && !bus.hold && ((up && count_q == MAX) || (dn && count_q == '0));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q <= wrap_d;
    end
  end
  assign {bus.c1, bus.c2, bus.c3, bus.c4, bus.c5} = count_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_code_counter.sv
// tb_code_counter: press-level reference model checks two counters (MAX_CODE 31 and 9) fed identical buttons
module tb_code_counter;
`ifdef CODE_COUNTER_DEBOUNCE_EN
  localparam int THR = 4;
  localparam int LAT = 7;
`else
  localparam int THR = 1;
  localparam int LAT = 3;
`endif
  logic clk = 0, rst_n = 0, up = 0, dn = 0, ld = 0, hold = 0;
  logic [4:0] lv = '0;
  logic [4:0] cnt_a, cnt_b;
  logic [4:0] ca = '0, cb = '0;
  int wa = 0, wb = 0, n_chk = 0, n_pass = 0;
  code_counter_if bus_a();
  code_counter_if bus_b();
  assign bus_a.btn_up = up;
  assign bus_a.btn_down = dn;
  assign bus_a.btn_load = ld;
  assign bus_a.load_val = lv;
  assign bus_a.hold = hold;
  assign bus_b.btn_up = up;
  assign bus_b.btn_down = dn;
  assign bus_b.btn_load = ld;
  assign bus_b.load_val = lv;
  assign bus_b.hold = hold;
  assign cnt_a = {bus_a.c1, bus_a.c2, bus_a.c3, bus_a.c4, bus_a.c5};
  assign cnt_b = {bus_b.c1, bus_b.c2, bus_b.c3, bus_b.c4, bus_b.c5};
  code_counter #(.DEB_CYCLES(4), .MAX_CODE(31)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  code_counter #(.DEB_CYCLES(4), .MAX_CODE(9)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus_a.wrap) wa++;
    if (bus_b.wrap) wb++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] nxt(input logic [4:0] c, input int mx, input bit u, input bit d,
                                     input bit l, input bit h, input logic [4:0] v, output bit w);
    w = 0;
    if (l) return (int'(v) > mx) ? 5'(mx) : v;
    if ((u && d) || h) return c;
    if (u) begin
      if (int'(c) == mx) begin w = 1; return '0; end
      return c + 5'd1;
    end
    if (d) begin
      if (c == '0) begin w = 1; return 5'(mx); end
      return c - 5'd1;
    end
    return c;
  endfunction
  task automatic txn(input bit u, input bit d, input bit l, input int len, input bit h, input logic [4:0] v);
    int wa0, wb0;
    bit wxa, wxb, seen;
    wa0 = wa;
    wb0 = wb;
    seen = len >= THR;
    hold = h; lv = v; up = u; dn = d; ld = l;
    cyc(len);
    up = 0; dn = 0; ld = 0;
    cyc(THR + 10);
    hold = 0;
    cyc(4);
    ca = nxt(ca, 31, u && seen, d && seen, l && seen, h, v, wxa);
    cb = nxt(cb, 9, u && seen, d && seen, l && seen, h, v, wxb);
    @(negedge clk);
    chk("count_max31", cnt_a, ca);
    chk("count_max9", cnt_b, cb);
    chk("wrap_pulses_max31", wa - wa0, int'(wxa));
    chk("wrap_pulses_max9", wb - wb0, int'(wxb));
  endtask
  initial begin
    int wa0;
    rst_n = 0;
    for (int i = 0; i < 8; i++) begin
      up = i[0]; dn = i[1]; ld = i[2];
      cyc(1);
    end
    @(negedge clk);
    chk("reset_count", cnt_a, 0);
    chk("reset_wrap", bus_a.wrap, 0);
    up = 0; dn = 0; ld = 0;
    cyc(1);
    rst_n = 1;
    cyc(THR + 10);
    @(negedge clk);
    chk("post_reset_idle", cnt_a, 0);
    chk("post_reset_idle_b", cnt_b, 0);
    cyc(1);
    up = 1;
    @(posedge clk);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("press_latency", cnt_a, i < LAT ? 0 : 1);
    end
    cyc(20 - LAT - 1);
    up = 0;
    cyc(THR + 10);
    ca = 1; cb = 1;
    @(negedge clk);
    chk("single_press_once", cnt_a, 1);
    txn(0, 0, 1, 6, 0, 5);
    txn(0, 1, 0, 3, 0, 0);
    txn(0, 1, 0, 6, 0, 0);
    txn(0, 0, 1, 6, 0, 31);
    txn(1, 0, 0, 6, 0, 0);
    txn(0, 1, 0, 6, 0, 0);
    txn(0, 0, 1, 6, 0, 5'b10110);
    txn(0, 0, 1, 6, 0, 20);
    txn(0, 0, 1, 6, 1, 3);
    txn(1, 1, 0, 6, 0, 0);
    txn(1, 0, 0, 6, 1, 0);
    wa0 = wa;
    rst_n = 0; up = 1;
    cyc(4);
    @(negedge clk);
    chk("reset_mid_op", cnt_b, 0);
    cyc(1);
    rst_n = 1;
    cyc(10);
    up = 0;
    cyc(THR + 10);
    ca = 1; cb = 1;
    @(negedge clk);
    chk("held_through_reset", cnt_a, 1);
    chk("held_through_reset_b", cnt_b, 1);
    chk("held_through_reset_wrap", wa - wa0, 0);
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 1'($urandom), ($urandom % 4) == 0, int'($urandom_range(1, 10)),
          ($urandom % 4) == 0, 5'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
